time_unit_counter: RTL and testbench
====================================

TIME_UNIT_COUNTER -- requirements
Module: time_unit_counter

Interface
REQ-001 Parameter MODULUS, default 60, count range 0..MODULUS-1, legal 2..100.
REQ-002 Parameter INIT, default 0, reset value of count, legal 0..MODULUS-1.
REQ-003 Localparam W = $clog2(MODULUS), count width.
REQ-004 clk_50  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 tick_i  in  1  level advance request from lower stage; counted on rising edge.
REQ-007 set_mode_i  in  1  0 = run, 1 = set.
REQ-008 sel_i  in  1  this counter selected for editing in set mode.
REQ-009 inc_n_i  in  1  increment key, active-low, already debounced.
REQ-010 dec_n_i  in  1  decrement key, active-low, already debounced.
REQ-011 carry_o  out  1  one-cycle pulse on run-mode wrap to 0.
REQ-012 value_o  out  W  binary count.
REQ-013 tens_o  out  4  BCD tens digit of count.
REQ-014 units_o  out  4  BCD units digit of count.
REQ-015 seg_tens_o, seg_units_o  out  7 each  active-low segments {g..a}.

Function
REQ-016 Each of tick_i, inc_n_i, dec_n_i SHALL pass one sync flop then one history flop; event = sync active & history inactive (tick rising, keys falling).
REQ-017 Count SHALL update on the 2nd rising edge after the input transition; exactly one step per edge regardless of hold duration.
REQ-018 Run mode: tick event -> count+1; at MODULUS-1 -> 0 with carry_o = 1 for exactly the following cycle; key events ignored.
REQ-019 Set mode, sel_i = 1: inc event -> +1, wrapping MODULUS-1 -> 0; dec event -> -1, wrapping 0 -> MODULUS-1; carry_o stays 0; tick events ignored (dropped, not queued).
REQ-020 Set mode, inc and dec events in same cycle SHALL leave count unchanged.
REQ-021 Set mode, sel_i = 0: count holds; all events dropped.
REQ-022 set_mode_i/sel_i SHALL be sampled at the same edge that applies the event; edge detectors run continuously in all modes.
REQ-023 tens_o/units_o SHALL be combinational from the count register (count/10, count%10); value_o is the register directly.

Reset
REQ-024 rst = 1 at an edge SHALL set count = INIT, carry_o = 0, tick sync/history = 1, key sync/history = 1; rst overrides every event in that cycle.
REQ-025 tick_i held high through reset release SHALL NOT produce an event; keys held low through release SHALL NOT produce an event.

Configuration
REQ-026 Macro TIME_UNIT_COUNTER_SEG7_EN defined: seg outputs SHALL decode tens_o/units_o, hex 0-9, active-low.
REQ-027 Macro undefined: seg_tens_o and seg_units_o SHALL be constant 7'h7F (blank); no decoder logic; all other behaviour identical.

Structure
REQ-028 Shared package tuc_pkg SHALL hold mode encodings (RUN=0, SET=1), SEG_BLANK = 7'h7F and the digit-to-segment table.
REQ-029 Sub-module edge_pulse (sync + history flop, parameter for active level and reset value) SHALL be instantiated three times.
REQ-030 Elaboration SHALL fail for MODULUS outside 2..100 or INIT >= MODULUS.

Verification
REQ-031 MODULUS=60, run, 59 tick pulses then 1 more -> value 59, then 0 with carry_o high exactly 1 cycle.
REQ-032 MODULUS=24, set, sel=1, one dec press from 0 -> 23; inc press from 23 -> 0; carry_o never asserts.
REQ-033 Set, sel=1, inc_n_i held low 100 cycles -> count advances by exactly 1.
REQ-034 Set, inc and dec falling in same cycle -> count unchanged; sel=0 with presses -> unchanged.
REQ-035 tick_i high during rst, release -> no increment; next low->high -> +1; rst asserted mid tick event -> count = INIT.
REQ-036 Count 37 with SEG7_EN -> tens 3, units 7, seg_tens_o 7'b0110000, seg_units_o 7'b1111000; without macro -> both 7'h7F.

Source files
------------

// File: rtl/time_unit_counter_pkg.sv
// Shared definitions for the time-unit counter: operating-mode encoding,
// the blank seven-segment pattern and the BCD digit-to-segment table.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package tuc_pkg;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40,  // 0
    7'h79,  // 1
    7'h24,  // 2
    7'h30,  // 3
    7'h19,  // 4
    7'h12,  // 5
    7'h02,  // 6
    7'h78,  // 7
    7'h00,  // 8
    7'h10   // 9
  };

  // Non-decimal codes blank the digit rather than showing garbage.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (digit < 4'd10) begin
      seg = SEG_TABLE[digit];
    end
    return seg;
  endfunction

endpackage

// File: rtl/time_unit_counter_edge_pulse.sv
// edge_pulse: one synchroniser flop followed by one history flop; emits a
// single-cycle pulse when the synchronised input reaches ACTIVE while the
// history flop still holds the opposite level.
//
// The two valid flags mark when sync and history really hold sampled input
// rather than their reset value. Without them, an input that is already
// active at reset release (e.g. a key held down) would meet a history flop
// still carrying the inactive reset value and fire a spurious event.
module edge_pulse #(
  parameter logic ACTIVE  = 1'b1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic pulse_o
);

  logic sync_q;
  logic hist_q;
  logic svld_q;
  logic hvld_q;

  // Sample the input, age it into history and track post-reset validity.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= RST_VAL;
      hist_q <= RST_VAL;
      svld_q <= 1'b0;
      hvld_q <= 1'b0;
    end else begin
      sync_q <= in_i;
      hist_q <= sync_q;
      svld_q <= 1'b1;
      hvld_q <= svld_q;
    end
  end

  assign pulse_o = hvld_q && (sync_q == ACTIVE) && (hist_q != ACTIVE);

endmodule

// File: rtl/time_unit_counter.sv
// time_unit_counter: modulo-MODULUS counter for a clock/timer chain.
// Run mode advances on rising edges of tick_i from the lower stage and
// pulses carry_o on wrap; set mode lets the user step the selected counter
// up or down with debounced active-low keys.
// Optional feature macro: TIME_UNIT_COUNTER_SEG7_EN enables the two
// seven-segment digit decoders; without it both segment outputs are blank.
module time_unit_counter
  import tuc_pkg::*;
#(
  parameter int MODULUS = 60,
  parameter int INIT    = 0,
  localparam int W      = $clog2(MODULUS)
) (
  input  logic         clk_50,
  input  logic         rst,
  input  logic         tick_i,
  input  logic         set_mode_i,
  input  logic         sel_i,
  input  logic         inc_n_i,
  input  logic         dec_n_i,
  output logic         carry_o,
  output logic [W-1:0] value_o,
  output logic [3:0]   tens_o,
  output logic [3:0]   units_o,
  output logic [6:0]   seg_tens_o,
  output logic [6:0]   seg_units_o
);

  generate
    if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
      $error("time_unit_counter: MODULUS must lie in 2..100");
    end
    if (INIT < 0 || INIT >= MODULUS) begin : g_bad_init
      $error("time_unit_counter: INIT must lie in 0..MODULUS-1");
    end
  endgenerate

  localparam logic [W-1:0] CNT_MAX  = W'(MODULUS - 1);
  localparam logic [W-1:0] CNT_INIT = W'(INIT);

  logic         tick_ev;
  logic         inc_ev;
  logic         dec_ev;
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         carry_q;
  logic         carry_d;
  mode_e        mode;

  // Tick is active-high; resetting its flops high means a tick held high
  // through reset release is seen as already-high, not as a rising edge.
  edge_pulse #(
    .ACTIVE  (1'b1),
    .RST_VAL (1'b1)
  ) u_tick_edge (
    .clk_i   (clk_50),
    .rst_i   (rst),
    .in_i    (tick_i),
    .pulse_o (tick_ev)
  );

  edge_pulse #(
    .ACTIVE  (1'b0),
    .RST_VAL (1'b1)
  ) u_inc_edge (
    .clk_i   (clk_50),
    .rst_i   (rst),
    .in_i    (inc_n_i),
    .pulse_o (inc_ev)
  );

  edge_pulse #(
    .ACTIVE  (1'b0),
    .RST_VAL (1'b1)
  ) u_dec_edge (
    .clk_i   (clk_50),
    .rst_i   (rst),
    .in_i    (dec_n_i),
    .pulse_o (dec_ev)
  );

  assign mode = mode_e'(set_mode_i);

  // Next count and carry: mode and select are taken in the same cycle the
  // event is applied; events not relevant to the current mode are dropped.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    case (mode)
      MODE_RUN: begin
        if (tick_ev) begin
          if (count_q == CNT_MAX) begin
            count_d = '0;
            carry_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      MODE_SET: begin
        // Simultaneous inc and dec cancel out.
        if (sel_i && (inc_ev != dec_ev)) begin
          if (inc_ev) begin
            count_d = (count_q == CNT_MAX) ? '0 : count_q + 1'b1;
          end else begin
            count_d = (count_q == '0) ? CNT_MAX : count_q - 1'b1;
          end
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Count and carry registers; reset wins over any pending event.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      count_q <= CNT_INIT;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign carry_o = carry_q;
  assign value_o = count_q;
  assign tens_o  = 4'(32'(count_q) / 10);
  assign units_o = 4'(32'(count_q) % 10);

`ifdef TIME_UNIT_COUNTER_SEG7_EN
  assign seg_tens_o  = seg_decode(tens_o);
  assign seg_units_o = seg_decode(units_o);
`else
  assign seg_tens_o  = SEG_BLANK;
  assign seg_units_o = SEG_BLANK;
`endif

endmodule

// File: tb/tb_time_unit_counter.sv
// Directed bench for time_unit_counter: a MODULUS=60/INIT=0 instance for run
// mode and a MODULUS=24/INIT=3 instance for set mode, sharing clock and reset.
module tb_time_unit_counter;

  logic       clk_50 = 1'b0;
  logic       rst;

  logic       tick_a, set_a, sel_a, inc_a, dec_a;
  logic       carry_a;
  logic [5:0] val_a;
  logic [3:0] tens_a, units_a;
  logic [6:0] segt_a, segu_a;

  logic       tick_b, set_b, sel_b, inc_b, dec_b;
  logic       carry_b;
  logic [4:0] val_b;
  logic [3:0] tens_b, units_b;
  logic [6:0] segt_b, segu_b;

  int total = 0;
  int bad   = 0;

  always #10 clk_50 = ~clk_50;

  time_unit_counter #(.MODULUS(60), .INIT(0)) u_dut60 (
    .clk_50      (clk_50),
    .rst         (rst),
    .tick_i      (tick_a),
    .set_mode_i  (set_a),
    .sel_i       (sel_a),
    .inc_n_i     (inc_a),
    .dec_n_i     (dec_a),
    .carry_o     (carry_a),
    .value_o     (val_a),
    .tens_o      (tens_a),
    .units_o     (units_a),
    .seg_tens_o  (segt_a),
    .seg_units_o (segu_a)
  );

  time_unit_counter #(.MODULUS(24), .INIT(3)) u_dut24 (
    .clk_50      (clk_50),
    .rst         (rst),
    .tick_i      (tick_b),
    .set_mode_i  (set_b),
    .sel_i       (sel_b),
    .inc_n_i     (inc_b),
    .dec_n_i     (dec_b),
    .carry_o     (carry_b),
    .value_o     (val_b),
    .tens_o      (tens_b),
    .units_o     (units_b),
    .seg_tens_o  (segt_b),
    .seg_units_o (segu_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic tick_pulse_a();
    tick_a = 1'b1;
    cyc(2);
    tick_a = 1'b0;
    cyc(2);
  endtask

  // Press keys of the 24 instance; carry is checked on the update cycle.
  task automatic key_b(input bit do_inc, input bit do_dec, input string tag);
    if (do_inc) inc_b = 1'b0;
    if (do_dec) dec_b = 1'b0;
    cyc(2);
    chk(tag, 32'(carry_b), 32'd0);
    inc_b = 1'b1;
    dec_b = 1'b1;
    cyc(2);
  endtask

  initial begin
    rst    = 1'b1;
    tick_a = 1'b1; set_a = 1'b0; sel_a = 1'b0; inc_a = 1'b1; dec_a = 1'b1;
    tick_b = 1'b0; set_b = 1'b1; sel_b = 1'b1; inc_b = 1'b0; dec_b = 1'b1;
    cyc(3);
    chk("rst_val60",   32'(val_a),   32'd0);
    chk("rst_carry60", 32'(carry_a), 32'd0);
    chk("rst_val24",   32'(val_b),   32'd3);
    chk("rst_carry24", 32'(carry_b), 32'd0);
    chk("rst_tens24",  32'(tens_b),  32'd0);
    chk("rst_units24", 32'(units_b), 32'd3);

    // Tick held high / inc key held low through release: no events.
    rst = 1'b0;
    cyc(4);
    chk("tick_held_rel", 32'(val_a), 32'd0);
    chk("key_held_rel",  32'(val_b), 32'd3);
    inc_b  = 1'b1;
    tick_a = 1'b0;
    cyc(2);

    tick_pulse_a();
    chk("first_tick", 32'(val_a), 32'd1);
    repeat (58) tick_pulse_a();
    chk("val59",        32'(val_a),   32'd59);
    chk("carry_at_59",  32'(carry_a), 32'd0);

    tick_a = 1'b1;
    cyc(2);
    chk("wrap_val",   32'(val_a),   32'd0);
    chk("wrap_carry", 32'(carry_a), 32'd1);
    cyc(1);
    chk("carry_one_cycle", 32'(carry_a), 32'd0);
    tick_a = 1'b0;
    cyc(2);

    // Keys are ignored in run mode.
    inc_a = 1'b0; cyc(3); inc_a = 1'b1; cyc(2);
    chk("run_inc_ignored", 32'(val_a), 32'd0);
    dec_a = 1'b0; cyc(3); dec_a = 1'b1; cyc(2);
    chk("run_dec_ignored", 32'(val_a), 32'd0);

    // Set mode on the 24 instance.
    key_b(1'b0, 1'b1, "dec_carry_a"); chk("dec_3to2", 32'(val_b), 32'd2);
    key_b(1'b0, 1'b1, "dec_carry_b"); chk("dec_2to1", 32'(val_b), 32'd1);
    key_b(1'b0, 1'b1, "dec_carry_c"); chk("dec_1to0", 32'(val_b), 32'd0);
    key_b(1'b0, 1'b1, "dec_carry_wrap"); chk("dec_0to23", 32'(val_b), 32'd23);
    chk("tens23",  32'(tens_b),  32'd2);
    chk("units23", 32'(units_b), 32'd3);
    key_b(1'b1, 1'b0, "inc_carry_wrap"); chk("inc_23to0", 32'(val_b), 32'd0);

    inc_b = 1'b0;
    cyc(100);
    inc_b = 1'b1;
    cyc(2);
    chk("inc_held_100", 32'(val_b), 32'd1);

    key_b(1'b1, 1'b1, "both_carry"); chk("both_keys", 32'(val_b), 32'd1);

    tick_b = 1'b1; cyc(3); tick_b = 1'b0; cyc(2);
    chk("set_tick_ignored", 32'(val_b), 32'd1);

    sel_b = 1'b0;
    key_b(1'b1, 1'b0, "unsel_inc_carry"); chk("unsel_inc", 32'(val_b), 32'd1);
    key_b(1'b0, 1'b1, "unsel_dec_carry"); chk("unsel_dec", 32'(val_b), 32'd1);

    // Reset landing on the edge that would apply a tick event.
    tick_pulse_a();
    tick_pulse_a();
    chk("pre_mid_rst", 32'(val_a), 32'd2);
    tick_a = 1'b1;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_val60", 32'(val_a), 32'd0);
    chk("mid_rst_val24", 32'(val_b), 32'd3);
    rst = 1'b0;
    cyc(3);
    chk("post_rst_tick_held", 32'(val_a), 32'd0);
    tick_a = 1'b0;
    cyc(2);

    repeat (37) tick_pulse_a();
    chk("val37",   32'(val_a),   32'd37);
    chk("tens37",  32'(tens_a),  32'd3);
    chk("units37", 32'(units_a), 32'd7);
`ifdef TIME_UNIT_COUNTER_SEG7_EN
    chk("seg_tens37",  32'(segt_a), 32'h30);
    chk("seg_units37", 32'(segu_a), 32'h78);
`else
    chk("seg_tens_blank",  32'(segt_a), 32'h7F);
    chk("seg_units_blank", 32'(segu_a), 32'h7F);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, want finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
